// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART receiver with 16x oversampling and a small receive FIFO.
//
// Received bytes land in a FIFO that the core reads over the peripheral bus.
// Offset 0 (RXDATA) pops the head byte. Offset 1 (STATUS) returns the flags and
// clears the sticky error flags.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous reset, active-low
//   Rx           serial line (asynchronous, idles high)
//   cs           chip select from the peripheral bus
//   re           read strobe
//   addr_i       0 = RXDATA, 1 = STATUS
//   rdata_o      read data (combinational)
//   rx_valid_o   FIFO not empty
//   frame_err_o  sticky framing-error flag
//
// Build option
//   UART_RX_PARITY_EN  frame becomes 8E1. A parity mismatch sets the sticky par_err
//                      flag (STATUS bit 4). The byte is still pushed.
//
// State table
//   IDLE   | line idle, waiting for a falling edge on rx_s
//   START  | confirm the start bit at mid-bit (8th tick)
//   DATA   | sample one data bit every 16 ticks, LSB first
//   PARITY | sample the parity bit (parity build only)
//   STOP   | sample the stop bit, then push the byte or flag an error
module uart_rx #(
    parameter int DW         = 8,
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Rx,
    input  logic        cs,
    input  logic        re,
    input  logic        addr_i,
    output logic [31:0] rdata_o,
    output logic        rx_valid_o,
    output logic        frame_err_o
);
    localparam int TICK_RAW = CLOCK_FREQ / (BAUD_RATE * 16);
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int IW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic             rx_meta, rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       cnt, cnt_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [DW-1:0]    shift, shift_nxt;
    logic             stop_sample;

    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic             empty, full;
    logic             rd_data, rd_stat, push_req, push, pop, ovr_set, fe_set;
    logic             overrun, frame_err, par_err;

    // Divider idles at its reload value, so the first tick in START comes TICK_DIV clocks after the edge.
    assign tick = (state != IDLE) && (div_cnt == '0);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        shift_nxt   = shift;
        stop_sample = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: if (tick) begin
                if (cnt == 4'd7) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DATA: if (tick) begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'd15) begin
                    shift_nxt[idx] = rx_s;
                    if (idx == IW'(DW - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'd15) state_nxt = STOP;
            end
`endif
            STOP: if (tick) begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'd15) begin
                    stop_sample = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign empty    = (count == '0);
    assign full     = (count == (PW + 1)'(FIFO_DEPTH));
    assign rd_data  = cs & re & ~addr_i;
    assign rd_stat  = cs & re & addr_i;
    assign pop      = rd_data & ~empty;
    assign push_req = stop_sample & rx_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push     = push_req & (~full | pop);
    assign ovr_set  = push_req & full & ~pop;
    assign fe_set   = stop_sample & ~rx_s;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            div_cnt   <= '0;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shift   <= shift_nxt;
            if (state == IDLE || div_cnt == '0) div_cnt <= DIV_RELOAD;
            else                                div_cnt <= div_cnt - 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // An error event in the same cycle as a STATUS read keeps the flag set.
            overrun   <= ovr_set | (overrun   & ~rd_stat);
            frame_err <= fe_set  | (frame_err & ~rd_stat);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= shift;
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    // Even parity: the data bits and the parity bit together carry an even number of ones.
    assign par_bad = (state == PARITY) && tick && (cnt == 4'd15) && (rx_s != ^shift);

    always_ff @(posedge clk_i) begin
        if (!rst_i) par_err <= 1'b0;
        else        par_err <= par_bad | (par_err & ~rd_stat);
    end
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        rdata_o = '0;
        if (rd_stat)
            rdata_o[4:0] = {par_err, overrun, frame_err, full, ~empty};
        else if (pop)
            rdata_o[DW-1:0] = mem[rd_ptr];
    end

    assign rx_valid_o  = ~empty;
    assign frame_err_o = frame_err;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        Rx;
    logic        cs;
    logic        re;
    logic        addr_i;
    logic [31:0] rdata_o;
    logic        rx_valid_o;
    logic        frame_err_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    bit          m_ovr, m_fe, m_par;

    always #5 clk_i = ~clk_i;

    uart_rx #(
        .DW(8),
        .CLOCK_FREQ(16_000_000),
        .BAUD_RATE(1_000_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .Rx(Rx),
        .cs(cs),
        .re(re),
        .addr_i(addr_i),
        .rdata_o(rdata_o),
        .rx_valid_o(rx_valid_o),
        .frame_err_o(frame_err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        Rx = v;
        repeat (16) @(negedge clk_i);
    endtask

    // Sends one frame, then updates the model of what the receiver should hold.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_bit);
        Rx = 1'b1;
        repeat (24) @(negedge clk_i);
        if (stop_bit) begin
            if (exp_q.size() < 4) exp_q.push_back(b);
            else                  m_ovr = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] exp;
        exp = '0;
        if (exp_q.size() > 0) exp = {24'b0, exp_q.pop_front()};
        cs = 1'b1; re = 1'b1; addr_i = 1'b0;
        #1 check(tag, rdata_o, exp);
        @(negedge clk_i);
        cs = 1'b0; re = 1'b0;
    endtask

    task automatic rd_status(input string tag);
        logic [31:0] exp;
        exp = {27'b0, m_par, m_ovr, m_fe, exp_q.size() == 4, exp_q.size() != 0};
        cs = 1'b1; re = 1'b1; addr_i = 1'b1;
        #1 check(tag, rdata_o, exp);
        m_par = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        @(negedge clk_i);
        cs = 1'b0; re = 1'b0; addr_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cycles;
        Rx = 1'b1; cs = 1'b0; re = 1'b0; addr_i = 1'b0; rst_i = 1'b0;
        m_ovr = 1'b0; m_fe = 1'b0; m_par = 1'b0;
        repeat (4) @(negedge clk_i);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_valid", {31'b0, rx_valid_o}, 32'h0);
        check("rst_ferr", {31'b0, frame_err_o}, 32'h0);
        rst_i = 1'b1;
        repeat (4) @(negedge clk_i);
        rd_status("rst_status");

        // 1: single byte and its arrival latency
        cycles = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!rx_valid_o && cycles < 400) begin
                    @(negedge clk_i);
                    cycles++;
                end
                check("t1_latency", {31'b0, (cycles >= 148 && cycles <= 160)}, 32'h1);
            end
        join
        rd_status("t1_status");
        rd_data("t1_data");
        check("t1_valid_after_pop", {31'b0, rx_valid_o}, 32'h0);

        // 2: short low glitch on the line
        Rx = 1'b0;
        repeat (4) @(negedge clk_i);
        Rx = 1'b1;
        repeat (40) @(negedge clk_i);
        check("t2_valid", {31'b0, rx_valid_o}, 32'h0);
        rd_status("t2_status");

        // 3: framing error
        send_frame(8'h3C, 1'b0);
        check("t3_ferr_o", {31'b0, frame_err_o}, 32'h1);
        check("t3_valid", {31'b0, rx_valid_o}, 32'h0);
        rd_status("t3_status");
        rd_status("t3_status_clr");

        // 4: overrun
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        rd_status("t4_status");
        for (int i = 0; i < 5; i++) rd_data($sformatf("t4_data%0d", i));

        // 5: pop coincides with the stop sample while the FIFO is full
        for (int i = 0; i < 4; i++) send_frame(8'(8'h10 + i), 1'b1);
        @(negedge clk_i);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (154) @(negedge clk_i);
                rd_data("t5_pop");
            end
        join
        rd_status("t5_status");
        for (int i = 0; i < 4; i++) rd_data($sformatf("t5_data%0d", i));

        // 6: reset in the middle of a frame
        send_frame(8'h99, 1'b1);
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst_i = 1'b0;
        Rx = 1'b1;
        repeat (2) @(negedge clk_i);
        exp_q.delete();
        m_ovr = 1'b0; m_fe = 1'b0; m_par = 1'b0;
        check("t6_valid", {31'b0, rx_valid_o}, 32'h0);
        check("t6_ferr_o", {31'b0, frame_err_o}, 32'h0);
        rd_status("t6_status_in_rst");
        rst_i = 1'b1;
        repeat (40) @(negedge clk_i);
        rd_status("t6_status");
        send_frame(8'h12, 1'b1);
        rd_data("t6_data");
        check("t6_valid_end", {31'b0, rx_valid_o}, 32'h0);

`ifdef UART_RX_PARITY_EN
        // 7: wrong parity still pushes the byte but flags par_err
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i < 3);
        drive_bit(1'b0);
        drive_bit(1'b1);
        repeat (24) @(negedge clk_i);
        exp_q.push_back(8'h07);
        m_par = 1'b1;
        rd_status("t7_status");
        rd_data("t7_data");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
